// File: rtl/func_sweep_ctrl_if.sv
// Handshake and result bundle between the sweep controller and its driver/units.
// The slave side is the controller; the master side is the bench/top-level.
interface func_sweep_ctrl_if #(
  parameter int WIDTH = 5
);
  logic             start;
  logic             abort;
  logic [2:0]       f_in;
  logic [WIDTH-1:0] vec_out;
  logic             vec_valid;
  logic             busy;
  logic             done;
  logic             pass;
  logic [WIDTH:0]   err_cnt;
  logic [WIDTH-1:0] first_err_code;
  logic [2:0]       first_err_bits;
  logic [2:0]       err_mask;

  modport slave (
    input  start, abort, f_in,
    output vec_out, vec_valid, busy, done, pass,
           err_cnt, first_err_code, first_err_bits, err_mask
  );

  modport master (
    output start, abort, f_in,
    input  vec_out, vec_valid, busy, done, pass,
           err_cnt, first_err_code, first_err_bits, err_mask
  );
endinterface

// File: rtl/func_sweep_ctrl.sv
// Drives every input code onto three function units in turn, waits out their
// latency, then majority-votes the three outputs and logs any disagreement.
module func_sweep_ctrl #(
  parameter int WIDTH = 5,
  parameter int LAT   = 1
) (
  input logic            clk,
  input logic            rst,
  func_sweep_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic maj3(input logic [2:0] f);
    return (f[0] & f[1]) | (f[0] & f[2]) | (f[1] & f[2]);
  endfunction

  state_t           state_r;
  logic [WIDTH-1:0] code_r;
  logic [3:0]       wcnt_r;
  logic [WIDTH-1:0] vec_r;
  logic             vec_valid_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;
  logic [WIDTH:0]   err_cnt_r;
  logic [WIDTH-1:0] first_err_code_r;
  logic [2:0]       first_err_bits_r;
  logic [2:0]       err_mask_r;

  logic             mismatch_s;
  logic [2:0]       diff_bits_s;
  logic             last_code_s;

  // Vote on the unit outputs; only consumed while in CHECK.
  always_comb begin
    mismatch_s  = (bus.f_in != 3'b000) && (bus.f_in != 3'b111);
    diff_bits_s = bus.f_in ^ {3{maj3(bus.f_in)}};
    last_code_s = (code_r == {WIDTH{1'b1}});
  end

  // Sweep sequencer with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r          <= S_IDLE;
      code_r           <= '0;
      wcnt_r           <= 4'd0;
      vec_r            <= '0;
      vec_valid_r      <= 1'b0;
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
      pass_r           <= 1'b0;
      err_cnt_r        <= '0;
      first_err_code_r <= '0;
      first_err_bits_r <= 3'b000;
      err_mask_r       <= 3'b000;
    end else if (bus.abort) begin
      // Abort keeps the partial error logs for post-mortem inspection.
      state_r     <= S_IDLE;
      vec_r       <= '0;
      vec_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_r          <= S_DRIVE;
            code_r           <= '0;
            vec_r            <= '0;
            vec_valid_r      <= 1'b1;
            busy_r           <= 1'b1;
            done_r           <= 1'b0;
            pass_r           <= 1'b0;
            err_cnt_r        <= '0;
            first_err_code_r <= '0;
            first_err_bits_r <= 3'b000;
            err_mask_r       <= 3'b000;
          end else begin
            state_r <= state_r;
          end
        end
        S_DRIVE: begin
          if (LAT == 32'sd0) begin
            state_r <= S_CHECK;
          end else begin
            state_r <= S_WAIT;
            wcnt_r  <= 4'(LAT - 32'sd1);
          end
        end
        S_WAIT: begin
          if (wcnt_r == 4'd0) begin
            state_r <= S_CHECK;
          end else begin
            wcnt_r <= wcnt_r - 4'd1;
          end
        end
        S_CHECK: begin
          if (mismatch_s) begin
            err_cnt_r  <= err_cnt_r + {{WIDTH{1'b0}}, 1'b1};
            err_mask_r <= err_mask_r | diff_bits_s;
            if (err_cnt_r == '0) begin
              first_err_code_r <= code_r;
              first_err_bits_r <= bus.f_in;
            end else begin
              first_err_code_r <= first_err_code_r;
            end
          end else begin
            err_cnt_r <= err_cnt_r;
          end
          if (last_code_s) begin
            state_r     <= S_DONE;
            vec_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            pass_r      <= (err_cnt_r == '0) && !mismatch_s;
          end else begin
            state_r <= S_DRIVE;
            code_r  <= code_r + {{(WIDTH-1){1'b0}}, 1'b1};
            vec_r   <= code_r + {{(WIDTH-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r     <= S_IDLE;
          vec_r       <= '0;
          vec_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          pass_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.vec_out        = vec_r;
  assign bus.vec_valid      = vec_valid_r;
  assign bus.busy           = busy_r;
  assign bus.done           = done_r;
  assign bus.pass           = pass_r;
  assign bus.err_cnt        = err_cnt_r;
  assign bus.first_err_code = first_err_code_r;
  assign bus.first_err_bits = first_err_bits_r;
  assign bus.err_mask       = err_mask_r;

endmodule

// File: tb/tb_func_sweep_ctrl.sv
// Directed bench for func_sweep_ctrl: LAT=1 main instance with fault-injected
// parity units, plus LAT=0 and LAT=3 instances checking sweep length.
module tb_func_sweep_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   mode = 0;
  int   checks = 0;
  int   errors = 0;
  logic [4:0] d1_r, d2_r, d3_r;

  always #5 clk = ~clk;

  func_sweep_ctrl_if #(.WIDTH(5)) bus1 ();
  func_sweep_ctrl_if #(.WIDTH(5)) bus0 ();
  func_sweep_ctrl_if #(.WIDTH(5)) bus3 ();

  func_sweep_ctrl #(.WIDTH(5), .LAT(1)) dut (.clk(clk), .rst(rst), .bus(bus1));
  func_sweep_ctrl #(.WIDTH(5), .LAT(0)) dut_l0 (.clk(clk), .rst(rst), .bus(bus0));
  func_sweep_ctrl #(.WIDTH(5), .LAT(3)) dut_l3 (.clk(clk), .rst(rst), .bus(bus3));

  function automatic logic [2:0] unit_model(input logic [4:0] v, input int m);
    logic p;
    p = ^v;
    case (m)
      1:       return (v == 5'd13) ? {~p, p, p} : {3{p}};
      2:       return {v[0], v[0], 1'b0};
      default: return {3{p}};
    endcase
  endfunction

  assign bus1.f_in = unit_model(bus1.vec_out, mode);
  assign bus0.f_in = {3{^bus0.vec_out}};

  // Three-stage delayed parity units for the LAT=3 instance.
  always_ff @(posedge clk) begin
    d1_r <= bus3.vec_out;
    d2_r <= d1_r;
    d3_r <= d2_r;
  end
  assign bus3.f_in = {3{^d3_r}};

  task automatic run_sweep(input bit spam, output int n);
    int bad;
    bad = 0;
    n = 0;
    @(negedge clk) bus1.start = 1'b1;
    @(posedge clk); #1 bus1.start = 1'b0;
    if (bus1.vec_out !== 5'd0 || bus1.busy !== 1'b1 || bus1.err_cnt !== 6'd0) bad++;
    for (int c = 1; c <= 400; c++) begin
      if (spam && (c % 7 == 3)) bus1.start = 1'b1;
      @(posedge clk); #1 bus1.start = 1'b0;
      if (bus1.done === 1'b1) begin n = c; break; end
      if (bus1.vec_out !== 5'(c / 3) || bus1.vec_valid !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL sweep_sequence: %0d bad cycles, required 0", bad);
    end
    checks++;
    if (n !== 96) begin
      errors++;
      $display("FAIL sweep_length: got %0d cycles, required 96", n);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({bus1.vec_out, bus1.vec_valid, bus1.busy, bus1.done, bus1.pass, bus1.err_cnt,
         bus1.first_err_code, bus1.first_err_bits, bus1.err_mask} !== 28'd0) begin
      errors++;
      $display("FAIL %s: outputs vec=%0d busy=%b done=%b err_cnt=%0d mask=%b, required all 0",
               name, bus1.vec_out, bus1.busy, bus1.done, bus1.err_cnt, bus1.err_mask);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset_state");
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_clean_sweep();
    int n;
    mode = 0;
    run_sweep(1'b0, n);
    checks++;
    if (bus1.pass !== 1'b1 || bus1.err_cnt !== 6'd0 || bus1.err_mask !== 3'b000) begin
      errors++;
      $display("FAIL clean_result: pass=%b err_cnt=%0d mask=%b, required 1/0/000",
               bus1.pass, bus1.err_cnt, bus1.err_mask);
    end
  endtask

  task automatic test_single_fault();
    int n;
    mode = 1;
    run_sweep(1'b0, n);
    checks++;
    if (bus1.err_cnt !== 6'd1) begin
      errors++; $display("FAIL fault13_cnt: got %0d, required 1", bus1.err_cnt);
    end
    checks++;
    if (bus1.first_err_code !== 5'd13 || bus1.first_err_bits !== 3'b011) begin
      errors++;
      $display("FAIL fault13_first: code=%0d bits=%b, required 13/011",
               bus1.first_err_code, bus1.first_err_bits);
    end
    checks++;
    if (bus1.err_mask !== 3'b100 || bus1.pass !== 1'b0) begin
      errors++;
      $display("FAIL fault13_mask: mask=%b pass=%b, required 100/0", bus1.err_mask, bus1.pass);
    end
  endtask

  task automatic test_stuck_unit();
    int n;
    mode = 2;
    run_sweep(1'b0, n);
    checks++;
    if (bus1.err_cnt !== 6'd16 || bus1.pass !== 1'b0) begin
      errors++;
      $display("FAIL stuck_cnt: err_cnt=%0d pass=%b, required 16/0", bus1.err_cnt, bus1.pass);
    end
    checks++;
    if (bus1.first_err_code !== 5'd1 || bus1.first_err_bits !== 3'b110 ||
        bus1.err_mask !== 3'b001) begin
      errors++;
      $display("FAIL stuck_first: code=%0d bits=%b mask=%b, required 1/110/001",
               bus1.first_err_code, bus1.first_err_bits, bus1.err_mask);
    end
  endtask

  task automatic test_abort();
    int n;
    bit seen;
    mode = 2;
    seen = 1'b0;
    @(negedge clk) bus1.start = 1'b1;
    @(posedge clk); #1 bus1.start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (bus1.vec_out === 5'd10) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL abort_reach: vec_out never reached 10");
    end
    @(negedge clk) begin bus1.abort = 1'b1; bus1.start = 1'b1; end
    @(posedge clk); #1 begin bus1.abort = 1'b0; bus1.start = 1'b0; end
    checks++;
    if (bus1.busy !== 1'b0 || bus1.vec_out !== 5'd0 || bus1.done !== 1'b0 ||
        bus1.vec_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: busy=%b vec=%0d done=%b valid=%b, required 0/0/0/0",
               bus1.busy, bus1.vec_out, bus1.done, bus1.vec_valid);
    end
    checks++;
    if (bus1.err_cnt !== 6'd5 || bus1.first_err_code !== 5'd1 || bus1.err_mask !== 3'b001) begin
      errors++;
      $display("FAIL abort_logs: err_cnt=%0d first=%0d mask=%b, required 5/1/001",
               bus1.err_cnt, bus1.first_err_code, bus1.err_mask);
    end
    mode = 0;
    run_sweep(1'b0, n);
    checks++;
    if (bus1.pass !== 1'b1 || bus1.err_cnt !== 6'd0 || bus1.first_err_code !== 5'd0) begin
      errors++;
      $display("FAIL abort_restart: pass=%b err_cnt=%0d first=%0d, required 1/0/0",
               bus1.pass, bus1.err_cnt, bus1.first_err_code);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    mode = 2;
    @(negedge clk) bus1.start = 1'b1;
    @(posedge clk); #1 bus1.start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (bus1.vec_out === 5'd20) break;
      @(posedge clk); #1;
    end
    @(negedge clk) rst = 1'b1;
    #1 check_all_zero("reset_mid_sweep");
    @(negedge clk) rst = 1'b0;
    mode = 0;
    run_sweep(1'b1, n);
    checks++;
    if (bus1.pass !== 1'b1 || bus1.err_cnt !== 6'd0) begin
      errors++;
      $display("FAIL reset_fresh: pass=%b err_cnt=%0d, required 1/0", bus1.pass, bus1.err_cnt);
    end
  endtask

  task automatic test_lat_variants();
    int n0, n3;
    n0 = 0;
    n3 = 0;
    @(negedge clk) begin bus0.start = 1'b1; bus3.start = 1'b1; end
    @(posedge clk); #1 begin bus0.start = 1'b0; bus3.start = 1'b0; end
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      if (n0 == 0 && bus0.done === 1'b1) n0 = c;
      if (n3 == 0 && bus3.done === 1'b1) n3 = c;
      if (n0 != 0 && n3 != 0) break;
    end
    checks++;
    if (n0 !== 64) begin errors++; $display("FAIL lat0_length: got %0d, required 64", n0); end
    checks++;
    if (n3 !== 160) begin errors++; $display("FAIL lat3_length: got %0d, required 160", n3); end
    checks++;
    if (bus0.pass !== 1'b1 || bus0.err_cnt !== 6'd0) begin
      errors++;
      $display("FAIL lat0_result: pass=%b err_cnt=%0d, required 1/0", bus0.pass, bus0.err_cnt);
    end
    checks++;
    if (bus3.pass !== 1'b1 || bus3.err_cnt !== 6'd0) begin
      errors++;
      $display("FAIL lat3_result: pass=%b err_cnt=%0d, required 1/0", bus3.pass, bus3.err_cnt);
    end
  endtask

  initial begin
    bus1.start = 1'b0; bus1.abort = 1'b0;
    bus0.start = 1'b0; bus0.abort = 1'b0;
    bus3.start = 1'b0; bus3.abort = 1'b0;
    test_reset();
    test_clean_sweep();
    test_single_fault();
    test_stuck_unit();
    test_abort();
    test_reset_mid_sweep();
    test_lat_variants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
